cycle_profiler_counters: RTL and testbench
==========================================

Name: cycle_profiler_counters

Overview:
- Parametrised successor to the single free-running cycle counter in the generated top: CHANNELS independent event counters plus a global cycle counter.
- Each channel counts cycles while its enable bit is high, used to profile decoder stages (busy, stall, syndrome-load) on FPGA runs.
- A snapshot request atomically captures every counter into shadow registers, then streams them out over a valid/ready handshake.
- Selectable wrap or saturate overflow mode, with sticky overflow flags.

Parameters:
- WIDTH, 32, bit width of every counter and of out_count.
- CHANNELS, 4, number of event counters, 1..64.
- SATURATE, 0, 0 = wrap to zero on overflow; 1 = hold at all-ones on overflow.
- IDX_W, max(1,$clog2(CHANNELS)), derived localparam; width of out_channel.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- clear  in  1  zero all channel counters, cycle_count and overflow flags.
- count_en  in  CHANNELS  bit i high = channel i increments this cycle.
- snap_req  in  1  request snapshot and readout; ignored while snap_busy.
- snap_busy  out  1  snapshot captured and readout in progress.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts the word.
- out_channel  out  IDX_W  channel index of the current word.
- out_count  out  WIDTH  snapshotted count of out_channel.
- out_last  out  1  high with the word for channel CHANNELS-1.
- overflow  out  CHANNELS  sticky per-channel overflow flag.
- cycle_count  out  WIDTH  free-running cycle counter; always wraps.

Behaviour:
- Reset (reset==0 at posedge): all counters, cycle_count, overflow, shadows = 0; state IDLE; snap_busy=0, out_valid=0, out_channel=0, out_last=0, out_count=0. Takes effect mid-stream: out_valid drops at that same edge, and the partial readout is abandoned.
- Counting: channel i increments by 1 at each posedge where count_en[i]=1. cycle_count increments at every non-reset posedge.
- Overflow: increment from all-ones sets overflow[i] sticky. SATURATE=0: counter becomes 0. SATURATE=1: counter holds all-ones. cycle_count never sets a flag.
- clear: counters, cycle_count and overflow become 0 at that edge. clear wins over count_en in the same cycle; no increment is applied.
- FSM IDLE:
  - snap_req=1 at a posedge copies every counter's pre-edge value (pre-increment, pre-clear) into the shadows.
  - Next state is STREAM; snap_busy=1, out_valid=1, out_channel=0.
- FSM STREAM:
  - out_count = shadow[out_channel]; out_last = (out_channel==CHANNELS-1).
  - While out_valid && !out_ready, out_channel/out_count/out_last hold stable.
  - On handshake with !out_last, out_channel increments.
  - On handshake with out_last, next state is IDLE; out_valid=0 and snap_busy=0 at that edge.
- Latency: snap_req edge to first valid word is 1 cycle. CHANNELS words take a minimum of CHANNELS cycles with out_ready held high.
- snap_req while snap_busy is ignored; it is not queued. A new snap_req in the cycle after returning to IDLE is accepted.
- Counting, clear and overflow continue during STREAM and never alter the shadows.
- CHANNELS=1: the single word has out_last=1 and out_channel=0.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> all outputs 0; after 10 idle cycles cycle_count=10 and channel counters stay 0.
- CHANNELS=4, count_en=4'b0101 for 5 cycles, snap_req pulse in the next cycle, out_ready=1 -> words (0,5),(1,0),(2,5),(3,0); out_last only on channel 3; snap_busy low after the 4th word.
- Same stream with out_ready toggling 1,0,0,1,... -> each word held stable while out_ready=0; no word skipped or duplicated.
- WIDTH=4, SATURATE=0, count_en[0]=1 for 17 cycles -> counter 1, overflow[0]=1. With SATURATE=1 -> counter 15, overflow[0]=1. Then clear -> counter 0, overflow 0.
- Same-cycle events: clear, snap_req and count_en=4'b1111 in one cycle with counters at 7 -> all snapshot words read 7 and all live counters read 0. snap_req again mid-stream -> ignored, word count stays 4.
- Assert reset=0 during word 2 of a stream -> out_valid=0 and snap_busy=0 at that edge. A fresh snap_req afterwards -> complete stream of zeros.

Source files
------------

// File: rtl/cycle_profiler_counters.sv
// cycle_profiler_counters: per-channel event counters plus a cycle counter,
// with atomic snapshot into shadows and a valid/ready readout stream.
module cycle_profiler_counters #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter bit SATURATE = 1'b0,
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [CHANNELS-1:0] count_en,
  input  logic                snap_req,
  output logic                snap_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_channel,
  output logic [WIDTH-1:0]    out_count,
  output logic                out_last,
  output logic [CHANNELS-1:0] overflow,
  output logic [WIDTH-1:0]    cycle_count
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);
  state_t              state_q;
  logic [IDX_W-1:0]    ch_q;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]    cyc_q, cyc_d;
  always_comb begin
    ovf_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = clear ? '0 :
                 !count_en[i] ? cnt_q[i] :
                 (SATURATE && &cnt_q[i]) ? cnt_q[i] : cnt_q[i] + WIDTH'(1);
      ovf_d[i] = !clear && (ovf_q[i] || (count_en[i] && &cnt_q[i]));
    end
    cyc_d = clear ? '0 : cyc_q + WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      ovf_q    <= '0;
      cyc_q    <= '0;
      cnt_q    <= '{default: '0};
      shadow_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
      if (state_q == IDLE) begin
        // shadows take the pre-edge values, before this cycle's increment or clear
        if (snap_req) begin
          shadow_q <= cnt_q;
          state_q  <= STREAM;
          ch_q     <= '0;
        end
      end else if (out_ready) begin
        if (ch_q == LAST) begin
          state_q <= IDLE;
          ch_q    <= '0;
        end else begin
          ch_q <= ch_q + IDX_W'(1);
        end
      end
    end
  end
  assign snap_busy   = (state_q == STREAM);
  assign out_valid   = (state_q == STREAM);
  assign out_channel = ch_q;
  assign out_count   = shadow_q[ch_q];
  assign out_last    = (state_q == STREAM) && (ch_q == LAST);
  assign overflow    = ovf_q;
  assign cycle_count = cyc_q;
endmodule

// File: tb/tb_cycle_profiler_counters.sv
// tb_cycle_profiler_counters: three DUT variants (wrap, saturate, single channel)
// driven in lockstep and checked against an event-count reference model.
module tb_cycle_profiler_counters;
  logic       clk = 1'b0;
  logic       reset = 1'b0, clear = 1'b0, snap_req = 1'b0, out_ready = 1'b0;
  logic [3:0] count_en = '0;
  int checks = 0, failures = 0, hs = 0;
  logic       o_b [3], o_v [3], o_l [3];
  logic [1:0] o_ch [3];
  logic [3:0] o_cnt [3], o_cy [3], o_of [3];
  logic [1:0] ch0, ch1;
  logic       ch2, of2;
  logic [3:0] of0, of1;
  always #5 clk = ~clk;
  cycle_profiler_counters #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .count_en(count_en), .snap_req(snap_req),
    .snap_busy(o_b[0]), .out_valid(o_v[0]), .out_ready(out_ready), .out_channel(ch0),
    .out_count(o_cnt[0]), .out_last(o_l[0]), .overflow(of0), .cycle_count(o_cy[0]));
  cycle_profiler_counters #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .count_en(count_en), .snap_req(snap_req),
    .snap_busy(o_b[1]), .out_valid(o_v[1]), .out_ready(out_ready), .out_channel(ch1),
    .out_count(o_cnt[1]), .out_last(o_l[1]), .overflow(of1), .cycle_count(o_cy[1]));
  cycle_profiler_counters #(.WIDTH(4), .CHANNELS(1), .SATURATE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .count_en(count_en[0:0]), .snap_req(snap_req),
    .snap_busy(o_b[2]), .out_valid(o_v[2]), .out_ready(out_ready), .out_channel(ch2),
    .out_count(o_cnt[2]), .out_last(o_l[2]), .overflow(of2), .cycle_count(o_cy[2]));
  assign o_ch[0] = ch0;
  assign o_ch[1] = ch1;
  assign o_ch[2] = {1'b0, ch2};
  assign o_of[0] = of0;
  assign o_of[1] = of1;
  assign o_of[2] = {3'b000, of2};

  // reference model: events since last clear/reset per channel, then derive values
  int n [4];
  int mcyc;
  bit mbusy [3];
  int midx [3];
  int msh [3][4];
  int nch [3] = '{4, 4, 1};
  bit msat [3] = '{1'b0, 1'b1, 1'b0};

  function automatic int val(input int x, input bit s);
    return s ? ((x > 15) ? 15 : x) : x % 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic [3:0] e, input logic s, input logic rd);
    logic [3:0] eo;
    reset = r; clear = c; count_en = e; snap_req = s; out_ready = rd;
    if (o_v[0] && rd) hs++;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 4; i++) n[i] = 0;
      mcyc = 0;
      for (int k = 0; k < 3; k++) begin
        mbusy[k] = 1'b0; midx[k] = 0;
        for (int i = 0; i < 4; i++) msh[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (mbusy[k]) begin
          if (rd) begin
            if (midx[k] == nch[k] - 1) begin mbusy[k] = 1'b0; midx[k] = 0; end
            else midx[k]++;
          end
        end else if (s) begin
          for (int i = 0; i < nch[k]; i++) msh[k][i] = val(n[i], msat[k]);
          mbusy[k] = 1'b1; midx[k] = 0;
        end
      end
      if (c) begin
        for (int i = 0; i < 4; i++) n[i] = 0;
        mcyc = 0;
      end else begin
        mcyc = (mcyc + 1) % 16;
        for (int i = 0; i < 4; i++) if (e[i]) n[i]++;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      eo = '0;
      for (int i = 0; i < nch[k]; i++) eo[i] = (n[i] >= 16);
      chk($sformatf("busy%0d", k), 32'(o_b[k]), 32'(mbusy[k]));
      chk($sformatf("valid%0d", k), 32'(o_v[k]), 32'(mbusy[k]));
      chk($sformatf("chan%0d", k), 32'(o_ch[k]), 32'(midx[k]));
      chk($sformatf("last%0d", k), 32'(o_l[k]), 32'(mbusy[k] && midx[k] == nch[k] - 1));
      chk($sformatf("cycle%0d", k), 32'(o_cy[k]), 32'(mcyc));
      chk($sformatf("ovf%0d", k), 32'(o_of[k]), 32'(eo));
      if (mbusy[k]) chk($sformatf("count%0d", k), 32'(o_cnt[k]), 32'(msh[k][midx[k]]));
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((o_b[0] || o_b[1] || o_b[2]) && g < 20) begin cyc(1, 0, 0, 0, 1); g++; end
    chk("drain_done", 32'(o_b[0] || o_b[1] || o_b[2]), 0);
  endtask

  typedef struct {
    logic clr; logic [3:0] en; logic snap; logic rdy;
    logic v; logic [1:0] ch; logic [3:0] cnt; logic last; logic [3:0] cy;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 4'h0, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{0, 4'h5, 0, 1, 0, 0, 0, 0, 4'(i)};
    tbl[6]  = '{0, 4'h0, 1, 1, 1, 0, 5, 0, 6};
    tbl[7]  = '{0, 4'h0, 0, 1, 1, 1, 0, 0, 7};
    tbl[8]  = '{0, 4'h0, 0, 1, 1, 2, 5, 0, 8};
    tbl[9]  = '{0, 4'h0, 0, 1, 1, 3, 0, 1, 9};
    tbl[10] = '{0, 4'h0, 0, 1, 0, 0, 0, 0, 10};
    // reset, then 10 idle cycles
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) chk("reset_count", 32'(o_cnt[k]), 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    chk("idle_cycle10", 32'(o_cy[0]), 10);
    // basic stream from table
    for (int i = 0; i < 11; i++) begin
      cyc(1, tbl[i].clr, tbl[i].en, tbl[i].snap, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(o_v[0]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_chan", i), 32'(o_ch[0]), 32'(tbl[i].ch));
      chk($sformatf("tbl%0d_last", i), 32'(o_l[0]), 32'(tbl[i].last));
      chk($sformatf("tbl%0d_cycle", i), 32'(o_cy[0]), 32'(tbl[i].cy));
      if (tbl[i].v) chk($sformatf("tbl%0d_count", i), 32'(o_cnt[0]), 32'(tbl[i].cnt));
    end
    // same stream with a stalling consumer
    hs = 0;
    cyc(1, 0, 0, 1, 1);
    for (int g = 0; g < 40 && o_b[0]; g++) cyc(1, 0, 0, 0, (g % 3) == 0);
    chk("stall_words", 32'(hs), 4);
    drain();
    // overflow: 17 events on channel 0
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 4'h1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk("wrap_val", 32'(o_cnt[0]), 1);
    chk("sat_val", 32'(o_cnt[1]), 15);
    chk("one_ch_val", 32'(o_cnt[2]), 1);
    chk("wrap_flag", 32'(o_of[0][0]), 1);
    chk("sat_flag", 32'(o_of[1][0]), 1);
    cyc(1, 1, 0, 0, 1);
    chk("clear_flag0", 32'(o_of[0]), 0);
    chk("clear_flag1", 32'(o_of[1]), 0);
    drain();
    // clear + snap + count in one cycle with counters at 7
    for (int i = 0; i < 7; i++) cyc(1, 0, 4'hf, 0, 0);
    cyc(1, 1, 4'hf, 1, 0);
    for (int k = 0; k < 3; k++) chk("same_cycle_snap", 32'(o_cnt[k]), 7);
    hs = 0;
    for (int g = 0; g < 10 && o_b[0]; g++) cyc(1, 0, 0, 1, 1);
    chk("ignored_snap_words", 32'(hs), 4);
    cyc(1, 0, 0, 1, 1);
    chk("live_cleared", 32'(o_cnt[0]), 0);
    drain();
    // reset during word 2
    cyc(1, 0, 4'h3, 1, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("word2_shown", 32'(o_ch[0]), 2);
    cyc(0, 0, 0, 0, 1);
    chk("rst_valid", 32'(o_v[0]), 0);
    chk("rst_busy", 32'(o_b[0]), 0);
    cyc(1, 0, 0, 1, 1);
    chk("post_rst_word", 32'(o_cnt[0]), 0);
    drain();
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0, 4'($urandom),
          $urandom_range(0, 3) == 0, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
